// File: rtl/byte_block_packer.sv
// Collects strobed bytes from the SD receive shift register into an AES block and
// presents it over valid/ready, with one fill buffer plus one output holding register.
module byte_block_packer #(
    parameter int NUM_BYTES = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic [7:0]                         byte_in,
    input  logic                               byte_valid,
    input  logic                               clear,
    input  logic                               block_ready,
    output logic [8*NUM_BYTES-1:0]             block_out,
    output logic                               block_valid,
    output logic [$clog2(NUM_BYTES+1)-1:0]     byte_count,
    output logic                               overrun
);

    localparam int BW = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES + 1);

    typedef enum logic {
        FILLING,
        HOLD
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   fill_q;
    logic [BW-1:0]   out_q;
    logic [CW-1:0]   cnt_q;
    logic            vld_q;
    logic            ovr_q;

    logic [BW-1:0]   full_d;
    logic [BW-1:0]   slot0_d;
    logic            drain;
    logic            last_byte;

    // Byte k lands in the lane chosen by MSB_FIRST; all other lanes are untouched.
    function automatic logic [BW-1:0] put_byte(input logic [BW-1:0] blk,
                                               input logic [CW-1:0] k,
                                               input logic [7:0]    b);
        logic [BW-1:0] r;
        r = blk;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (int'(k) == (MSB_FIRST ? NUM_BYTES - 1 - i : i)) begin
                r[8*i +: 8] = b;
            end
        end
        return r;
    endfunction

    assign drain     = vld_q & block_ready;
    assign last_byte = (cnt_q == CW'(NUM_BYTES - 1));
    assign full_d    = put_byte(fill_q, cnt_q, byte_in);
    assign slot0_d   = put_byte('0, '0, byte_in);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= FILLING;
            fill_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (clear) begin
            state_q <= FILLING;
            fill_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                FILLING: begin
                    // A drain empties the output register unless a new block replaces it below.
                    if (drain) begin
                        vld_q <= 1'b0;
                    end
                    if (byte_valid) begin
                        if (!last_byte) begin
                            fill_q <= full_d;
                            cnt_q  <= cnt_q + 1'b1;
                        end else if (!vld_q || drain) begin
                            out_q  <= full_d;
                            vld_q  <= 1'b1;
                            fill_q <= '0;
                            cnt_q  <= '0;
                        end else begin
                            fill_q  <= full_d;
                            cnt_q   <= CW'(NUM_BYTES);
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (drain) begin
                        out_q   <= fill_q;
                        state_q <= FILLING;
                        fill_q  <= byte_valid ? slot0_d : '0;
                        cnt_q   <= byte_valid ? CW'(1) : '0;
                    end else if (byte_valid) begin
                        ovr_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign block_out   = out_q;
    assign block_valid = vld_q;
    assign byte_count  = cnt_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_byte_block_packer.sv
// Scoreboard bench for byte_block_packer: one MSB-first and one LSB-first instance share stimulus.
module tb_byte_block_packer;

    localparam int N  = 16;
    localparam int BW = 8 * N;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          clear;
    logic          block_ready;

    logic [BW-1:0] out_m, out_l;
    logic          vld_m, vld_l;
    logic [CW-1:0] cnt_m, cnt_l;
    logic          ovr_m, ovr_l;

    logic [BW-1:0] q_m[$];
    logic [BW-1:0] q_l[$];

    int n_checks = 0;
    int n_errors = 0;

    byte_block_packer #(.NUM_BYTES(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .n_rst(n_rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .clear(clear), .block_ready(block_ready), .block_out(out_m),
        .block_valid(vld_m), .byte_count(cnt_m), .overrun(ovr_m)
    );

    byte_block_packer #(.NUM_BYTES(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .n_rst(n_rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .clear(clear), .block_ready(block_ready), .block_out(out_l),
        .block_valid(vld_l), .byte_count(cnt_l), .overrun(ovr_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference block built by shifting bytes in, independent of lane indexing.
    function automatic logic [BW-1:0] blk(input logic [7:0] first, input bit msb);
        logic [BW-1:0] r;
        logic [7:0]    b;
        r = '0;
        for (int k = 0; k < N; k++) begin
            b = first + 8'(k);
            if (msb) r = {r[BW-9:0], b};
            else     r = {b, r[BW-1:8]};
        end
        return r;
    endfunction

    task automatic push_blk(input logic [7:0] first);
        q_m.push_back(blk(first, 1'b1));
        q_l.push_back(blk(first, 1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send(first + 8'(i));
    endtask

    // Scoreboard: every completed handshake pops and compares; a clear cancels the pending block.
    always @(negedge clk) begin
        if (n_rst && block_ready) begin
            if (vld_m) begin
                if (clear) begin
                    if (q_m.size() != 0) void'(q_m.pop_front());
                end else begin
                    chk("drain_expected_m", 128'(q_m.size() != 0), 128'd1);
                    if (q_m.size() != 0) chk("block_m", out_m, q_m.pop_front());
                end
            end
            if (vld_l) begin
                if (clear) begin
                    if (q_l.size() != 0) void'(q_l.pop_front());
                end else begin
                    chk("drain_expected_l", 128'(q_l.size() != 0), 128'd1);
                    if (q_l.size() != 0) chk("block_l", out_l, q_l.pop_front());
                end
            end
        end
    end

    initial begin
        n_rst       = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        clear       = 1'b0;
        block_ready = 1'b0;
        repeat (2) tick();
        chk("rst_out", out_m, '0);
        chk("rst_valid", 128'(vld_m), 128'd0);
        chk("rst_count", 128'(cnt_m), 128'd0);
        chk("rst_overrun", 128'(ovr_m), 128'd0);
        n_rst = 1'b1;
        tick();

        // Single block, both byte orders, drained immediately
        block_ready = 1'b1;
        send_seq(8'h00, 5);
        chk("count5", 128'(cnt_m), 128'd5);
        send_seq(8'h05, 11);
        push_blk(8'h00);
        chk("latency_valid", 128'(vld_m), 128'd1);
        chk("msb_block", out_m, 128'h000102030405060708090A0B0C0D0E0F);
        chk("lsb_block", out_l, 128'h0F0E0D0C0B0A09080706050403020100);
        tick();
        chk("drained_valid", 128'(vld_m), 128'd0);
        chk("drained_count", 128'(cnt_m), 128'd0);
        chk("no_overrun", 128'(ovr_m), 128'd0);

        // Backpressure: two blocks buffered, third stream byte dropped
        block_ready = 1'b0;
        send_seq(8'h00, 16);
        push_blk(8'h00);
        send_seq(8'h10, 16);
        push_blk(8'h10);
        chk("hold_count", 128'(cnt_m), 128'd16);
        chk("hold_out", out_m, blk(8'h00, 1'b1));
        chk("hold_valid", 128'(vld_m), 128'd1);
        send(8'h20);
        chk("overrun_set", 128'(ovr_m), 128'd1);
        chk("drop_keeps_count", 128'(cnt_m), 128'd16);
        block_ready = 1'b1;
        tick();
        chk("second_valid", 128'(vld_m), 128'd1);
        chk("second_out", out_m, blk(8'h10, 1'b1));
        chk("after_hold_count", 128'(cnt_m), 128'd0);
        tick();
        chk("b2b_valid_low", 128'(vld_m), 128'd0);
        chk("overrun_sticky", 128'(ovr_m), 128'd1);

        // HOLD drain coinciding with a new byte
        block_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_overrun", 128'(ovr_m), 128'd0);
        send_seq(8'h40, 16);
        push_blk(8'h40);
        send_seq(8'h50, 16);
        push_blk(8'h50);
        block_ready = 1'b1;
        send(8'hAA);
        chk("hold_drain_out", out_m, blk(8'h50, 1'b1));
        chk("hold_drain_valid", 128'(vld_m), 128'd1);
        chk("hold_drain_count", 128'(cnt_m), 128'd1);
        chk("hold_drain_ovr", 128'(ovr_m), 128'd0);
        send_seq(8'hAB, 15);
        push_blk(8'hAA);
        tick();
        chk("aa_drained", 128'(vld_m), 128'd0);

        // clear mid-fill with a simultaneous byte, then a clean block
        send_seq(8'h60, 5);
        byte_in = 8'h77; byte_valid = 1'b1; clear = 1'b1;
        tick();
        byte_valid = 1'b0; clear = 1'b0;
        chk("clr_count", 128'(cnt_m), 128'd0);
        chk("clr_valid", 128'(vld_m), 128'd0);
        chk("clr_overrun", 128'(ovr_m), 128'd0);
        send_seq(8'h80, 16);
        push_blk(8'h80);
        tick();
        chk("clean_drained", 128'(vld_m), 128'd0);

        // clear cancels a handshake even with block_ready high
        block_ready = 1'b0;
        send_seq(8'h90, 16);
        push_blk(8'h90);
        block_ready = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; block_ready = 1'b0;
        chk("cancel_valid", 128'(vld_m), 128'd0);

        // Asynchronous reset mid-fill with a block pending
        send_seq(8'hC0, 16);
        push_blk(8'hC0);
        send_seq(8'hD0, 9);
        chk("pre_rst_count", 128'(cnt_m), 128'd9);
        chk("pre_rst_valid", 128'(vld_m), 128'd1);
        #3;
        n_rst = 1'b0;
        #1;
        chk("arst_out_m", out_m, '0);
        chk("arst_out_l", out_l, '0);
        chk("arst_valid", 128'(vld_m), 128'd0);
        chk("arst_count", 128'(cnt_m), 128'd0);
        chk("arst_overrun", 128'(ovr_m), 128'd0);
        q_m.delete();
        q_l.delete();
        tick();
        n_rst = 1'b1;
        tick();

        // Fresh block after reset
        block_ready = 1'b1;
        send_seq(8'hE0, 16);
        push_blk(8'hE0);
        tick();
        chk("final_valid", 128'(vld_m), 128'd0);
        chk("q_m_empty", 128'(q_m.size()), 128'd0);
        chk("q_l_empty", 128'(q_l.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
